// File: rtl/seg7_pkg.sv
// Shared constants and the BCD-to-segment mapping for common-anode
// 7-segment displays. Segment order is {dp,g,f,e,d,c,b,a}, active-low.
package seg7_pkg;

  // Active-low segment patterns; dp (bit 7) is always off
  localparam logic [7:0] SEG_0     = 8'hC0;
  localparam logic [7:0] SEG_1     = 8'hF9;
  localparam logic [7:0] SEG_2     = 8'hA4;
  localparam logic [7:0] SEG_3     = 8'hB0;
  localparam logic [7:0] SEG_4     = 8'h99;
  localparam logic [7:0] SEG_5     = 8'h92;
  localparam logic [7:0] SEG_6     = 8'h82;
  localparam logic [7:0] SEG_7     = 8'hF8;
  localparam logic [7:0] SEG_8     = 8'h80;
  localparam logic [7:0] SEG_9     = 8'h90;
  localparam logic [7:0] SEG_DASH  = 8'hBF;
  localparam logic [7:0] SEG_BLANK = 8'hFF;

  // All four anodes released (common-anode, active-low)
  localparam logic [3:0] AN_OFF = 4'b1111;

  // Scan position within a frame; positions 0/1 carry digits, 2/3 stay dark
  typedef logic [1:0] slot_idx_t;

  // Codes 10-15 are not BCD and show a dash so a bad counter value is visible
  function automatic logic [7:0] bcd_to_seg(input logic [3:0] bcd);
    logic [7:0] pattern;
    case (bcd)
      4'd0:    pattern = SEG_0;
      4'd1:    pattern = SEG_1;
      4'd2:    pattern = SEG_2;
      4'd3:    pattern = SEG_3;
      4'd4:    pattern = SEG_4;
      4'd5:    pattern = SEG_5;
      4'd6:    pattern = SEG_6;
      4'd7:    pattern = SEG_7;
      4'd8:    pattern = SEG_8;
      4'd9:    pattern = SEG_9;
      default: pattern = SEG_DASH;
    endcase
    return pattern;
  endfunction

endpackage

// File: rtl/seg7_decode.sv
// Combinational BCD to active-low 7-segment decoder, reusable by any
// display block sharing the {dp,g,f,e,d,c,b,a} segment order.
module seg7_decode
  import seg7_pkg::*;
(
  input  logic [3:0] bcd,
  output logic [7:0] seg
);

  assign seg = bcd_to_seg(bcd);

endmodule

// File: rtl/seg7_scan_drv.sv
// Two-digit scan driver for a 4-position common-anode 7-segment display.
// Digits are latched once per frame so a frame never mixes old and new
// values; "00" blinks with a period of 2*BLINK_FRAMES frames.
module seg7_scan_drv
  import seg7_pkg::*;
#(
  parameter int SCAN_DIV     = 50000,
  parameter int GUARD        = 2,
  parameter int BLINK_FRAMES = 64
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] bcd0,
  input  logic [3:0] bcd1,
  input  logic       en,
  output logic [3:0] an,
  output logic [7:0] seg
);

  localparam int SLOT_W  = $clog2(SCAN_DIV);
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [SLOT_W-1:0]  SLOT_LAST  = SLOT_W'(SCAN_DIV - 1);
  localparam logic [SLOT_W-1:0]  GUARD_END  = SLOT_W'(GUARD);
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [SLOT_W-1:0]  slot_cnt;
  slot_idx_t          idx;
  logic [FRAME_W-1:0] frame_cnt;
  logic               blink_on;
  logic [3:0]         d0;
  logic [3:0]         d1;

  logic               slot_wrap;
  logic               frame_wrap;
  logic               zero;
  logic [3:0]         cur_digit;
  logic [7:0]         dec_seg;
  logic               blank;

  assign slot_wrap  = (slot_cnt == SLOT_LAST);
  assign frame_wrap = slot_wrap && (idx == 2'd3);
  assign zero       = (d1 == 4'd0) && (d0 == 4'd0);

  // Slot timer and digit position; position advances each time a slot ends
  // NOTE: sequential state uses <= so every flop samples pre-edge values
  // regardless of block ordering.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slot_cnt <= '0;
      idx      <= 2'd0;
    end else if (slot_wrap) begin
      slot_cnt <= '0;
      idx      <= idx + 2'd1;
    end else begin
      slot_cnt <= slot_cnt + SLOT_W'(1);
    end
  end

  // Latch the counter's digits at the frame boundary only
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      d0 <= 4'd0;
      d1 <= 4'd0;
    end else if (frame_wrap) begin
      d0 <= bcd0;
      d1 <= bcd1;
    end
  end

  // Blink phase: held in the "on" phase until "00" is latched, then toggles
  // every BLINK_FRAMES frames
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (!zero) begin
      frame_cnt <= '0;
      blink_on  <= 1'b1;
    end else if (frame_wrap) begin
      if (frame_cnt == FRAME_LAST) begin
        frame_cnt <= '0;
        blink_on  <= ~blink_on;
      end else begin
        frame_cnt <= frame_cnt + FRAME_W'(1);
      end
    end
  end

  // Pick the digit for the current position and decide whether it is dark
  // NOTE: every signal gets a default before any branch so no latch can be
  // inferred.
  always_comb begin
    cur_digit = d0;
    blank     = 1'b0;
    if (idx == 2'd1) cur_digit = d1;
    if (slot_cnt < GUARD_END)                        blank = 1'b1;
    if (!en)                                         blank = 1'b1;
    if (idx[1])                                      blank = 1'b1;
    if ((idx == 2'd1) && (d1 == 4'd0) && !zero)      blank = 1'b1;
    if (zero && !blink_on)                           blank = 1'b1;
  end

  seg7_decode u_decode (
    .bcd (cur_digit),
    .seg (dec_seg)
  );

  // Registered pin drivers; at most one anode is ever pulled low
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else if (blank) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else begin
      an  <= ~(4'b0001 << idx);
      seg <= dec_seg;
    end
  end

endmodule

// File: tb/tb_seg7_scan_drv.sv
// Self-checking bench for seg7_scan_drv with a frame-level reference model.
module tb_seg7_scan_drv;

  localparam int SD    = 8;
  localparam int G     = 1;
  localparam int BF    = 2;
  localparam int FRAME = 4 * SD;

  logic       clk  = 1'b0;
  logic       rst  = 1'b1;
  logic [3:0] bcd0 = 4'd0;
  logic [3:0] bcd1 = 4'd0;
  logic       en   = 1'b1;
  logic [3:0] an;
  logic [7:0] seg;

  always #5 clk = ~clk;

  seg7_scan_drv #(
    .SCAN_DIV     (SD),
    .GUARD        (G),
    .BLINK_FRAMES (BF)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .bcd0 (bcd0),
    .bcd1 (bcd1),
    .en   (en),
    .an   (an),
    .seg  (seg)
  );

  int vectors     = 0;
  int miscompares = 0;
  bit check_en    = 1'b0;

  // Standard digit shapes, written out independently of the design package
  logic [7:0] seg_rom [0:15] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92,
                                 8'h82, 8'hF8, 8'h80, 8'h90, 8'hBF, 8'hBF,
                                 8'hBF, 8'hBF, 8'hBF, 8'hBF};

  // Reference model state: edges since reset, digits shown this frame and
  // how many consecutive "00" frames preceded this one
  int         edges   = 0;
  logic [3:0] md0     = 4'd0;
  logic [3:0] md1     = 4'd0;
  int         zrun    = 0;
  logic [3:0] exp_an  = 4'hF;
  logic [7:0] exp_seg = 8'hFF;
  int         m_slot;
  int         m_pos;
  bit         m_zero;
  bit         m_lit;
  logic [3:0] m_dig;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (edge %0d, t=%0t)", name, act, exp, edges, $time);
    end
  endtask

  // Expected output for the edge just taken, from slot/frame arithmetic
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      edges   = 0;
      md0     = 4'd0;
      md1     = 4'd0;
      zrun    = 0;
      exp_an  = 4'hF;
      exp_seg = 8'hFF;
    end else begin
      m_slot = edges % SD;
      m_pos  = (edges / SD) % 4;
      m_zero = (md0 == 4'd0) && (md1 == 4'd0);
      m_lit  = en && (m_slot >= G) && (m_pos < 2);
      if (m_pos == 1 && md1 == 4'd0 && !m_zero) m_lit = 1'b0;
      if (m_zero && ((zrun / BF) % 2) != 0)     m_lit = 1'b0;
      m_dig   = (m_pos == 0) ? md0 : md1;
      exp_an  = m_lit ? ~(4'b0001 << m_pos) : 4'hF;
      exp_seg = m_lit ? seg_rom[m_dig] : 8'hFF;
      if (edges % FRAME == FRAME - 1) begin
        zrun = (m_zero && bcd0 == 4'd0 && bcd1 == 4'd0) ? zrun + 1 : 0;
        md0  = bcd0;
        md1  = bcd1;
      end
      edges++;
    end
  end

  // Every-cycle comparison against the model, plus the one-anode invariant
  always @(negedge clk) begin
    if (check_en) begin
      check("an", {4'h0, an}, {4'h0, exp_an});
      check("seg", seg, exp_seg);
      check("one_anode", 8'($countones(~an) <= 1), 8'd1);
    end
  end

  task automatic wait_edges(input int m);
    while (edges < m) @(negedge clk);
  endtask

  task automatic pin(input string name, input logic [3:0] a, input logic [7:0] s);
    check({name, ".an"}, {4'h0, an}, {4'h0, a});
    check({name, ".seg"}, seg, s);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: run did not complete, got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    // Reset state
    @(negedge clk);
    @(negedge clk);
    check_en = 1'b1;
    pin("reset", 4'hF, 8'hFF);
    bcd1 = 4'd2;
    bcd0 = 4'd7;
    en   = 1'b1;
    @(negedge clk);
    rst = 1'b0;

    // Frame 0 shows the reset digits "00"; frame 1 shows "27"
    wait_edges(1);  pin("guard0", 4'hF, 8'hFF);
    wait_edges(2);  pin("first_lit", 4'b1110, 8'hC0);
    wait_edges(34); pin("ones7", 4'b1110, 8'hF8);
    wait_edges(42); pin("tens2", 4'b1101, 8'hA4);
    wait_edges(44); bcd0 = 4'd6;
    wait_edges(46); pin("tens2_hold", 4'b1101, 8'hA4);
    wait_edges(50); pin("idx2_dark", 4'hF, 8'hFF);
    wait_edges(66); pin("ones6", 4'b1110, 8'h82);

    // Leading-zero blank
    wait_edges(70);  bcd1 = 4'd0; bcd0 = 4'd5;
    wait_edges(98);  pin("ones5", 4'b1110, 8'h92);
    wait_edges(106); pin("lz_blank", 4'hF, 8'hFF);

    // Expiry: frames 4,5 on; 6,7 off; 8,9 on; 10 off
    wait_edges(110); bcd0 = 4'd0;
    wait_edges(130); pin("z_ones", 4'b1110, 8'hC0);
    wait_edges(138); pin("z_tens", 4'b1101, 8'hC0);
    wait_edges(162); pin("z_on2", 4'b1110, 8'hC0);
    wait_edges(194); pin("z_off1", 4'hF, 8'hFF);
    wait_edges(226); pin("z_off2", 4'hF, 8'hFF);
    wait_edges(258); pin("z_on3", 4'b1110, 8'hC0);
    wait_edges(322); pin("z_off3", 4'hF, 8'hFF);
    bcd0 = 4'd1;
    wait_edges(354); pin("one_after_z", 4'b1110, 8'hF9);

    // Invalid code and enable
    wait_edges(356); bcd0 = 4'hC;
    wait_edges(362); pin("lz_blank2", 4'hF, 8'hFF);
    wait_edges(386); pin("dash", 4'b1110, 8'hBF);
    wait_edges(390); en = 1'b0;
    wait_edges(392); pin("en_off", 4'hF, 8'hFF);
    wait_edges(400); bcd1 = 4'd3; bcd0 = 4'd8;
    wait_edges(426); pin("en_off2", 4'hF, 8'hFF);
    en = 1'b1;
    wait_edges(427); pin("en_back", 4'b1101, 8'hB0);

    // Async reset in the middle of an idx1 slot
    wait_edges(460); pin("pre_rst", 4'b1101, 8'hB0);
    #2 rst = 1'b1;
    #1 pin("async_rst", 4'hF, 8'hFF);
    repeat (3) @(negedge clk);
    rst = 1'b0;
    wait_edges(1);  pin("rst_guard", 4'hF, 8'hFF);
    wait_edges(2);  pin("rst_idx0", 4'b1110, 8'hC0);
    wait_edges(34); pin("rst_ones8", 4'b1110, 8'h80);
    wait_edges(42); pin("rst_tens3", 4'b1101, 8'hB0);
    wait_edges(48);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
